// File: rtl/mc_main_ctrl.sv
// Multicycle main controller: sequences fetch/decode/execute/mem/writeback
// with req/ack handshakes to variable-latency instruction and data memory.
module mc_main_ctrl #(
  parameter  int OP_W         = 6,
  parameter  int MEM_WAIT_MAX = 15,
  localparam int CNT_W        = $clog2(MEM_WAIT_MAX + 1)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [OP_W-1:0] op,
  input  logic            imem_ack,
  input  logic            dmem_ack,
  output logic            imem_req,
  output logic            dmem_req,
  output logic            memwrite,
  output logic            ir_we,
  output logic            pc_we,
  output logic            regwrite,
  output logic            regdst,
  output logic            alusrc,
  output logic            memtoreg,
  output logic            branch,
  output logic            jump,
  output logic            retire,
  output logic            ri_err,
  output logic            bus_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_RWB, S_EXEC_I, S_IWB, S_MEMADDR,
    S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH, S_JUMP, S_RSVD, S_ERR
  } state_t;

  state_t           r_state;
  state_t           w_next;
  state_t           w_dec_state;
  logic             w_dec_store;
  logic             r_is_store;
  logic [CNT_W-1:0] r_cnt;
  logic             w_wait_max;
  logic             w_in_req;

  assign w_wait_max = (r_cnt == CNT_W'(MEM_WAIT_MAX));
  assign w_in_req   = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                      (r_state == S_MEMWR);

  // Opcode class decode; only consumed while in DECODE.
  always_comb begin
    w_dec_state = S_RSVD;
    w_dec_store = 1'b0;
    case (op)
      OP_W'(6'h00): w_dec_state = S_EXEC_R;
      OP_W'(6'h20), OP_W'(6'h21), OP_W'(6'h23), OP_W'(6'h24), OP_W'(6'h25):
        w_dec_state = S_MEMADDR;
      OP_W'(6'h28), OP_W'(6'h29), OP_W'(6'h2B): begin
        w_dec_state = S_MEMADDR;
        w_dec_store = 1'b1;
      end
      OP_W'(6'h01), OP_W'(6'h04), OP_W'(6'h05), OP_W'(6'h06), OP_W'(6'h07):
        w_dec_state = S_BRANCH;
      OP_W'(6'h02), OP_W'(6'h03): w_dec_state = S_JUMP;
      OP_W'(6'h08), OP_W'(6'h09), OP_W'(6'h0A), OP_W'(6'h0B),
      OP_W'(6'h0C), OP_W'(6'h0D), OP_W'(6'h0E), OP_W'(6'h0F):
        w_dec_state = S_EXEC_I;
      default: w_dec_state = S_RSVD;
    endcase
  end

  // Next-state logic; a waiting request times out only when the counter is
  // already at MEM_WAIT_MAX and ack is still low (ack at MAX wins).
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    w_next = S_FETCH;
      S_FETCH:   if (imem_ack) w_next = S_DECODE;
                 else if (w_wait_max) w_next = S_ERR;
      S_DECODE:  w_next = w_dec_state;
      S_EXEC_R:  w_next = S_RWB;
      S_RWB:     w_next = S_FETCH;
      S_EXEC_I:  w_next = S_IWB;
      S_IWB:     w_next = S_FETCH;
      S_MEMADDR: w_next = r_is_store ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (dmem_ack) w_next = S_MEMWB;
                 else if (w_wait_max) w_next = S_ERR;
      S_MEMWB:   w_next = S_FETCH;
      S_MEMWR:   if (dmem_ack) w_next = S_FETCH;
                 else if (w_wait_max) w_next = S_ERR;
      S_BRANCH:  w_next = S_FETCH;
      S_JUMP:    w_next = S_FETCH;
      S_RSVD:    w_next = S_FETCH;
      S_ERR:     w_next = S_ERR;
      default:   w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Load/store flag captured from the opcode while in DECODE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                  r_is_store <= 1'b0;
    else if (r_state == S_DECODE) r_is_store <= w_dec_store;
  end

  // Wait counter: cleared on any state change (covers entry to each request
  // state), counts request cycles that see no ack.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                r_cnt <= '0;
    else if (w_next != r_state) r_cnt <= '0;
    else if (w_in_req)          r_cnt <= r_cnt + CNT_W'(1);
  end

  // Strobes decoded from state; ack only qualifies the handshake-completion
  // strobes (IR/PC load in FETCH, retire in MEMWR) so they land in the ack cycle.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    memwrite = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    alusrc   = 1'b0;
    memtoreg = 1'b0;
    branch   = 1'b0;
    jump     = 1'b0;
    retire   = 1'b0;
    ri_err   = 1'b0;
    bus_err  = 1'b0;
    case (r_state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ack;
        pc_we    = imem_ack;
      end
      S_RWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        retire   = 1'b1;
      end
      S_EXEC_I:  alusrc = 1'b1;
      S_IWB: begin
        regwrite = 1'b1;
        alusrc   = 1'b1;
        retire   = 1'b1;
      end
      S_MEMADDR: alusrc = 1'b1;
      S_MEMRD:   dmem_req = 1'b1;
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        retire   = 1'b1;
      end
      S_MEMWR: begin
        dmem_req = 1'b1;
        memwrite = 1'b1;
        alusrc   = 1'b1;
        retire   = dmem_ack;
      end
      S_BRANCH: begin
        branch = 1'b1;
        retire = 1'b1;
      end
      S_JUMP: begin
        jump   = 1'b1;
        retire = 1'b1;
      end
      S_RSVD:  ri_err  = 1'b1;
      S_ERR:   bus_err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Testbench for mc_main_ctrl: per-cycle expected strobe vectors are queued
// with their stimulus, then replayed and compared against the DUT outputs.
module tb_mc_main_ctrl;

  logic       clk;
  logic       resetn;
  logic [5:0] op;
  logic       imem_ack, dmem_ack;
  logic       imem_req, dmem_req, memwrite, ir_we, pc_we, regwrite, regdst;
  logic       alusrc, memtoreg, branch, jump, retire, ri_err, bus_err;

  int checks = 0;
  int errors = 0;

  localparam logic [13:0] IMREQ = 14'h2000;
  localparam logic [13:0] DMREQ = 14'h1000;
  localparam logic [13:0] MEMWR = 14'h0800;
  localparam logic [13:0] IRWE  = 14'h0400;
  localparam logic [13:0] PCWE  = 14'h0200;
  localparam logic [13:0] RGWR  = 14'h0100;
  localparam logic [13:0] RGDST = 14'h0080;
  localparam logic [13:0] ALUS  = 14'h0040;
  localparam logic [13:0] M2R   = 14'h0020;
  localparam logic [13:0] BRN   = 14'h0010;
  localparam logic [13:0] JMP   = 14'h0008;
  localparam logic [13:0] RET   = 14'h0004;
  localparam logic [13:0] RIE   = 14'h0002;
  localparam logic [13:0] BUSE  = 14'h0001;
  localparam logic [13:0] NONE  = 14'h0000;
  localparam logic [13:0] FACK  = IMREQ | IRWE | PCWE;

  localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4, C_J = 5, C_RI = 6;

  logic [13:0] obs;
  assign obs = {imem_req, dmem_req, memwrite, ir_we, pc_we, regwrite, regdst,
                alusrc, memtoreg, branch, jump, retire, ri_err, bus_err};

  typedef struct {
    logic        ia;
    logic        da;
    logic [5:0]  opc;
    logic [13:0] exp;
  } ent_t;

  ent_t sb[$];

  mc_main_ctrl #(.OP_W(6), .MEM_WAIT_MAX(4)) dut (
    .clk(clk), .resetn(resetn), .op(op),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .memwrite(memwrite),
    .ir_we(ir_we), .pc_we(pc_we), .regwrite(regwrite), .regdst(regdst),
    .alusrc(alusrc), .memtoreg(memtoreg), .branch(branch), .jump(jump),
    .retire(retire), .ri_err(ri_err), .bus_err(bus_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic push(input logic ia, input logic da, input logic [5:0] o,
                      input logic [13:0] e);
    ent_t x;
    x.ia = ia; x.da = da; x.opc = o; x.exp = e;
    sb.push_back(x);
  endtask

  task automatic do_reset();
    resetn = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; op = '0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  function automatic int op_class(input logic [5:0] o);
    case (o)
      6'h00: return C_R;
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: return C_LD;
      6'h28, 6'h29, 6'h2B: return C_ST;
      6'h01, 6'h04, 6'h05, 6'h06, 6'h07: return C_BR;
      6'h02, 6'h03: return C_J;
      default: return (o >= 6'h08 && o <= 6'h0F) ? C_I : C_RI;
    endcase
  endfunction

  task automatic test_reset();
    resetn = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b1; op = 6'h00;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (obs !== NONE) begin
      errors++;
      $display("FAIL reset_hold got %b exp %b", obs, NONE);
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_addu();
    ent_t e;
    int n = 0;
    do_reset();
    push(0, 0, 6'h00, NONE);
    push(1, 0, 6'h00, FACK);
    push(0, 0, 6'h00, NONE);
    push(0, 0, 6'h00, NONE);
    push(0, 0, 6'h00, RGWR | RGDST | RET);
    push(0, 0, 6'h00, IMREQ);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      imem_ack = e.ia; dmem_ack = e.da; op = e.opc;
      #1;
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("FAIL addu cyc%0d got %b exp %b", n, obs, e.exp);
      end
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_lw();
    ent_t e;
    int n = 0;
    do_reset();
    push(0, 0, 6'h23, NONE);
    push(1, 0, 6'h23, FACK);
    push(0, 0, 6'h23, NONE);
    push(0, 0, 6'h23, ALUS);
    push(0, 0, 6'h23, DMREQ);
    push(1, 0, 6'h23, DMREQ);
    push(0, 0, 6'h23, DMREQ);
    push(0, 1, 6'h23, DMREQ);
    push(0, 0, 6'h23, RGWR | M2R | RET);
    push(0, 0, 6'h23, IMREQ);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      imem_ack = e.ia; dmem_ack = e.da; op = e.opc;
      #1;
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("FAIL lw cyc%0d got %b exp %b", n, obs, e.exp);
      end
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_sw();
    ent_t e;
    int n = 0;
    do_reset();
    push(0, 0, 6'h2B, NONE);
    push(0, 0, 6'h2B, IMREQ);
    push(0, 0, 6'h2B, IMREQ);
    push(1, 0, 6'h2B, FACK);
    push(0, 1, 6'h2B, NONE);
    push(0, 0, 6'h2B, ALUS);
    push(0, 1, 6'h2B, DMREQ | MEMWR | ALUS | RET);
    push(0, 0, 6'h2B, IMREQ);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      imem_ack = e.ia; dmem_ack = e.da; op = e.opc;
      #1;
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("FAIL sw cyc%0d got %b exp %b", n, obs, e.exp);
      end
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reserved();
    ent_t e;
    int n = 0;
    do_reset();
    push(0, 0, 6'h3F, NONE);
    push(1, 0, 6'h3F, FACK);
    push(0, 0, 6'h3F, NONE);
    push(0, 0, 6'h3F, RIE);
    push(0, 0, 6'h3F, IMREQ);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      imem_ack = e.ia; dmem_ack = e.da; op = e.opc;
      #1;
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("FAIL reserved cyc%0d got %b exp %b", n, obs, e.exp);
      end
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [12] = '{6'h08, 6'h04, 6'h02, 6'h03, 6'h01, 6'h0F,
                             6'h24, 6'h30, 6'h22, 6'h2A, 6'h29, 6'h05};
    ent_t e;
    int n = 0;
    do_reset();
    push(0, 0, 6'h00, NONE);
    for (int i = 0; i < 12; i++) begin
      push(1, 0, ops[i], FACK);
      push(0, 0, ops[i], NONE);
      case (op_class(ops[i]))
        C_R: begin
          push(0, 0, ops[i], NONE);
          push(0, 0, ops[i], RGWR | RGDST | RET);
        end
        C_I: begin
          push(0, 0, ops[i], ALUS);
          push(0, 0, ops[i], RGWR | ALUS | RET);
        end
        C_LD: begin
          push(0, 0, ops[i], ALUS);
          push(0, 1, ops[i], DMREQ);
          push(0, 0, ops[i], RGWR | M2R | RET);
        end
        C_ST: begin
          push(0, 0, ops[i], ALUS);
          push(0, 1, ops[i], DMREQ | MEMWR | ALUS | RET);
        end
        C_BR: push(0, 0, ops[i], BRN | RET);
        C_J:  push(0, 0, ops[i], JMP | RET);
        default: push(0, 0, ops[i], RIE);
      endcase
    end
    push(0, 0, 6'h00, IMREQ);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      imem_ack = e.ia; dmem_ack = e.da; op = e.opc;
      #1;
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("FAIL b2b cyc%0d op=%h got %b exp %b", n, e.opc, obs, e.exp);
      end
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    ent_t e;
    int n = 0;
    // imem never acks: MAX+1 request cycles, then sticky bus error
    do_reset();
    push(0, 0, 6'h00, NONE);
    for (int i = 0; i < 5; i++) push(0, 0, 6'h00, IMREQ);
    push(1, 1, 6'h00, BUSE);
    push(0, 0, 6'h00, BUSE);
    push(1, 0, 6'h00, BUSE);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      imem_ack = e.ia; dmem_ack = e.da; op = e.opc;
      #1;
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("FAIL imem_timeout cyc%0d got %b exp %b", n, obs, e.exp);
      end
      n++;
      @(negedge clk);
    end
    // ack arriving when the counter sits at MAX is accepted
    n = 0;
    do_reset();
    push(0, 0, 6'h00, NONE);
    for (int i = 0; i < 4; i++) push(0, 0, 6'h00, IMREQ);
    push(1, 0, 6'h00, FACK);
    push(0, 0, 6'h00, NONE);
    push(0, 0, 6'h00, NONE);
    push(0, 0, 6'h00, RGWR | RGDST | RET);
    push(0, 0, 6'h00, IMREQ);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      imem_ack = e.ia; dmem_ack = e.da; op = e.opc;
      #1;
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("FAIL ack_at_max cyc%0d got %b exp %b", n, obs, e.exp);
      end
      n++;
      @(negedge clk);
    end
    // dmem never acks on a load
    n = 0;
    do_reset();
    push(0, 0, 6'h20, NONE);
    push(1, 0, 6'h20, FACK);
    push(0, 0, 6'h20, NONE);
    push(0, 0, 6'h20, ALUS);
    for (int i = 0; i < 5; i++) push(0, 0, 6'h20, DMREQ);
    push(0, 1, 6'h20, BUSE);
    push(1, 1, 6'h20, BUSE);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      imem_ack = e.ia; dmem_ack = e.da; op = e.opc;
      #1;
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("FAIL dmem_timeout cyc%0d got %b exp %b", n, obs, e.exp);
      end
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    ent_t e;
    int n = 0;
    do_reset();
    push(0, 0, 6'h23, NONE);
    push(1, 0, 6'h23, FACK);
    push(0, 0, 6'h23, NONE);
    push(0, 0, 6'h23, ALUS);
    push(0, 0, 6'h23, DMREQ);
    push(0, 0, 6'h23, DMREQ);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      imem_ack = e.ia; dmem_ack = e.da; op = e.opc;
      #1;
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("FAIL async_pre cyc%0d got %b exp %b", n, obs, e.exp);
      end
      n++;
      if (sb.size() > 0) @(negedge clk);
    end
    // drop reset between clock edges while MEMRD is waiting
    #1;
    resetn = 1'b0;
    #1;
    checks++;
    if (obs !== NONE) begin
      errors++;
      $display("FAIL async_reset got %b exp %b", obs, NONE);
    end
    dmem_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    n = 0;
    push(0, 1, 6'h23, NONE);
    push(0, 1, 6'h23, IMREQ);
    push(1, 1, 6'h23, FACK);
    push(0, 1, 6'h23, NONE);
    push(0, 1, 6'h23, ALUS);
    push(0, 1, 6'h23, DMREQ);
    push(0, 0, 6'h23, RGWR | M2R | RET);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      imem_ack = e.ia; dmem_ack = e.da; op = e.opc;
      #1;
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("FAIL async_post cyc%0d got %b exp %b", n, obs, e.exp);
      end
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; op = '0;
    test_reset();
    test_addu();
    test_lw();
    test_sw();
    test_reserved();
    test_back_to_back();
    test_timeout();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
